// File: rtl/apb_slave_demux.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_demux
// Purpose  : Routes each transfer arriving on a single upstream APB port to
//            one of NUM_APB_SLAVES downstream APB slaves. The slave is chosen
//            by decoding PADDR[SEL_MSB:SEL_LSB]. Every transfer is re-timed
//            through a registered FSM. Unmapped addresses get a local error
//            response, and a per-transfer watchdog ends hung slave accesses
//            with an error.
// Ports    : PCLK, PRESETn            - clock, asynchronous active-low reset
//            P*_s  (PSEL..PPROT in)   - upstream APB request
//            PRDATA_s/PREADY_s/PSLVERR_s (out) - upstream APB response
//            PSEL_m (out, one-hot)    - downstream slave selects
//            PENABLE_m..PPROT_m (out) - shared, registered downstream request
//            PRDATA_m/PREADY_m/PSLVERR_m (in) - per-slave responses
//            timeout_o (out)          - one-cycle pulse when watchdog fires
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_demux #(
    parameter int NUM_APB_SLAVES = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int SEL_MSB        = 31,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                     PCLK,
    input  logic                                     PRESETn,
    // upstream side
    input  logic                                     PSEL_s,
    input  logic                                     PENABLE_s,
    input  logic [APB_ADDR_WIDTH-1:0]                PADDR_s,
    input  logic                                     PWRITE_s,
    input  logic [APB_DATA_WIDTH-1:0]                PWDATA_s,
    input  logic [APB_DATA_WIDTH/8-1:0]              PSTRB_s,
    input  logic [2:0]                               PPROT_s,
    output logic [APB_DATA_WIDTH-1:0]                PRDATA_s,
    output logic                                     PREADY_s,
    output logic                                     PSLVERR_s,
    // downstream side
    output logic [NUM_APB_SLAVES-1:0]                PSEL_m,
    output logic                                     PENABLE_m,
    output logic [APB_ADDR_WIDTH-1:0]                PADDR_m,
    output logic                                     PWRITE_m,
    output logic [APB_DATA_WIDTH-1:0]                PWDATA_m,
    output logic [APB_DATA_WIDTH/8-1:0]              PSTRB_m,
    output logic [2:0]                               PPROT_m,
    input  logic [NUM_APB_SLAVES*APB_DATA_WIDTH-1:0] PRDATA_m,
    input  logic [NUM_APB_SLAVES-1:0]                PREADY_m,
    input  logic [NUM_APB_SLAVES-1:0]                PSLVERR_m,
    output logic                                     timeout_o
);

    localparam int c_FIELD_W = SEL_MSB - SEL_LSB + 1;
    localparam int c_IDX_W   = (NUM_APB_SLAVES > 1) ? $clog2(NUM_APB_SLAVES) : 1;
    localparam int c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t               state_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic [c_CNT_W-1:0]   wdog_q;
    logic                 abort_q;   // upstream dropped PSEL_s mid-transfer

    // ------------------------------------------------------------------
    // Address decode of the incoming setup phase
    // ------------------------------------------------------------------
    logic [c_FIELD_W-1:0]      w_field;
    logic                      w_mapped;
    logic [c_IDX_W-1:0]        w_idx;
    logic [NUM_APB_SLAVES-1:0] w_idx_onehot;

    assign w_field  = PADDR_s[SEL_MSB:SEL_LSB];
    assign w_mapped = (32'(w_field) < 32'(NUM_APB_SLAVES));
    assign w_idx    = c_IDX_W'(w_field);

    always_comb begin
        w_idx_onehot = '0;
        for (int i = 0; i < NUM_APB_SLAVES; i++) begin
            if (w_idx == c_IDX_W'(i)) begin
                w_idx_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response of the currently selected slave
    // ------------------------------------------------------------------
    logic                      w_slv_ready;
    logic                      w_slv_err;
    logic [APB_DATA_WIDTH-1:0] w_slv_rdata;
    logic                      w_keep;
    logic                      w_wdog_expired;

    assign w_slv_ready    = PREADY_m[idx_q];
    assign w_slv_err      = PSLVERR_m[idx_q];
    assign w_slv_rdata    = PRDATA_m[int'(idx_q) * APB_DATA_WIDTH +: APB_DATA_WIDTH];
    // The response is only forwarded if the upstream master is still
    // holding the transfer, including in the completing cycle itself.
    assign w_keep         = !abort_q && PSEL_s;
    // wdog_q counts not-ready ACCESS cycles already spent; the current
    // cycle is the last one allowed when it equals TIMEOUT_CYCLES-1.
    assign w_wdog_expired = (wdog_q == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------
    // Transfer FSM; every output is a register written on the transition
    // into the state that owns it.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wdog_q    <= '0;
            abort_q   <= 1'b0;
            PRDATA_s  <= '0;
            PREADY_s  <= 1'b0;
            PSLVERR_s <= 1'b0;
            PSEL_m    <= '0;
            PENABLE_m <= 1'b0;
            PADDR_m   <= '0;
            PWRITE_m  <= 1'b0;
            PWDATA_m  <= '0;
            PSTRB_m   <= '0;
            PPROT_m   <= '0;
            timeout_o <= 1'b0;
        end else begin
            // Single-cycle outputs default low; PRDATA_s/PSLVERR_s are
            // only non-zero alongside PREADY_s.
            PREADY_s  <= 1'b0;
            PSLVERR_s <= 1'b0;
            PRDATA_s  <= '0;
            timeout_o <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (PSEL_s && !PENABLE_s) begin
                        PADDR_m  <= PADDR_s;
                        PWRITE_m <= PWRITE_s;
                        PWDATA_m <= PWDATA_s;
                        PSTRB_m  <= PSTRB_s;
                        PPROT_m  <= PPROT_s;
                        abort_q  <= 1'b0;
                        if (w_mapped) begin
                            idx_q   <= w_idx;
                            PSEL_m  <= w_idx_onehot;
                            state_q <= S_SETUP;
                        end else begin
                            PREADY_s  <= 1'b1;
                            PSLVERR_s <= 1'b1;
                            state_q   <= S_ERR;
                        end
                    end
                end

                S_SETUP: begin
                    if (!PSEL_s) begin
                        abort_q <= 1'b1;
                    end
                    PENABLE_m <= 1'b1;
                    wdog_q    <= '0;
                    state_q   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (!PSEL_s) begin
                        abort_q <= 1'b1;
                    end
                    // Slave ready wins over the watchdog in the final cycle.
                    if (w_slv_ready) begin
                        PSEL_m    <= '0;
                        PENABLE_m <= 1'b0;
                        state_q   <= S_RESP;
                        if (w_keep) begin
                            PREADY_s  <= 1'b1;
                            PSLVERR_s <= w_slv_err;
                            PRDATA_s  <= PWRITE_m ? '0 : w_slv_rdata;
                        end
                    end else if (w_wdog_expired) begin
                        PSEL_m    <= '0;
                        PENABLE_m <= 1'b0;
                        timeout_o <= 1'b1;
                        PREADY_s  <= w_keep;
                        PSLVERR_s <= w_keep;
                        state_q   <= S_RESP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end

                S_RESP, S_ERR: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    PSEL_m    <= '0;
                    PENABLE_m <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_demux
// Purpose  : Self-checking bench for apb_slave_demux. Directed upstream
//            transfers drive the DUT while bench slaves answer with
//            configurable wait states, data and errors. A timeline model
//            predicts every registered output per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_demux;

    localparam int NS   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 16;
    localparam int MAXC = 1024;

    logic              PCLK    = 1'b0;
    logic              PRESETn = 1'b0;
    logic              PSEL_s, PENABLE_s, PWRITE_s;
    logic [AW-1:0]     PADDR_s;
    logic [DW-1:0]     PWDATA_s;
    logic [DW/8-1:0]   PSTRB_s;
    logic [2:0]        PPROT_s;
    logic [DW-1:0]     PRDATA_s;
    logic              PREADY_s, PSLVERR_s;
    logic [NS-1:0]     PSEL_m;
    logic              PENABLE_m, PWRITE_m;
    logic [AW-1:0]     PADDR_m;
    logic [DW-1:0]     PWDATA_m;
    logic [DW/8-1:0]   PSTRB_m;
    logic [2:0]        PPROT_m;
    logic [NS*DW-1:0]  PRDATA_m;
    logic [NS-1:0]     PREADY_m, PSLVERR_m;
    logic              timeout_o;

    apb_slave_demux #(
        .NUM_APB_SLAVES (NS),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .SEL_MSB        (31),
        .SEL_LSB        (28),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL_s    (PSEL_s),
        .PENABLE_s (PENABLE_s),
        .PADDR_s   (PADDR_s),
        .PWRITE_s  (PWRITE_s),
        .PWDATA_s  (PWDATA_s),
        .PSTRB_s   (PSTRB_s),
        .PPROT_s   (PPROT_s),
        .PRDATA_s  (PRDATA_s),
        .PREADY_s  (PREADY_s),
        .PSLVERR_s (PSLVERR_s),
        .PSEL_m    (PSEL_m),
        .PENABLE_m (PENABLE_m),
        .PADDR_m   (PADDR_m),
        .PWRITE_m  (PWRITE_m),
        .PWDATA_m  (PWDATA_m),
        .PSTRB_m   (PSTRB_m),
        .PPROT_m   (PPROT_m),
        .PRDATA_m  (PRDATA_m),
        .PREADY_m  (PREADY_m),
        .PSLVERR_m (PSLVERR_m),
        .timeout_o (timeout_o)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Bench slaves: waits < 0 means never ready. Unselected slaves hold
    // PREADY high so a wrong-slave decode shows up as wrong timing.
    // ------------------------------------------------------------------
    int            slv_waits[NS];
    logic [DW-1:0] slv_rdata[NS];
    logic [NS-1:0] slv_err;
    int            acc_cnt = 0;

    always @(posedge PCLK) acc_cnt <= PENABLE_m ? acc_cnt + 1 : 0;

    always_comb begin
        PREADY_m  = '1;
        PRDATA_m  = '0;
        PSLVERR_m = slv_err;
        for (int i = 0; i < NS; i++) begin
            PRDATA_m[i*DW +: DW] = slv_rdata[i];
            if (PSEL_m[i] && PENABLE_m)
                PREADY_m[i] = (slv_waits[i] >= 0) && (acc_cnt >= slv_waits[i]);
        end
    end

    // ------------------------------------------------------------------
    // Timeline model: expected value of every output for each cycle.
    // ------------------------------------------------------------------
    bit [NS-1:0]   e_psel [MAXC];
    bit            e_pen  [MAXC];
    bit            e_rdy  [MAXC];
    bit            e_err  [MAXC];
    bit [DW-1:0]   e_rdata[MAXC];
    bit            e_tmo  [MAXC];
    bit [AW-1:0]   e_addr [MAXC];
    bit            e_wr   [MAXC];
    bit [DW-1:0]   e_wdata[MAXC];
    bit [DW/8-1:0] e_strb [MAXC];
    bit [2:0]      e_prot [MAXC];

    // Transfer whose setup phase is seen in cycle t0.
    task automatic model_xfer(input int t0, input logic [31:0] a, input bit w,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [2:0] p, input bit keep);
        int  idx;
        int  n;
        int  r;
        bit  to;
        idx = int'(a[31:28]);
        for (int c = t0 + 1; c < MAXC; c++) begin
            e_addr[c] = a; e_wr[c] = w; e_wdata[c] = d; e_strb[c] = s; e_prot[c] = p;
        end
        if (idx >= NS) begin
            r = t0 + 1;
            e_rdy[r] = keep; e_err[r] = keep; e_rdata[r] = '0;
        end else begin
            to = (slv_waits[idx] < 0) || (slv_waits[idx] >= TMO);
            n  = to ? TMO : slv_waits[idx] + 1;          // ACCESS cycles
            for (int c = t0 + 1; c <= t0 + 1 + n; c++) e_psel[c] = 4'b0001 << idx;
            for (int c = t0 + 2; c <= t0 + 1 + n; c++) e_pen[c] = 1'b1;
            r = t0 + 2 + n;
            e_rdy[r]   = keep;
            e_err[r]   = keep && (to || slv_err[idx]);
            e_rdata[r] = (keep && !to && !w) ? slv_rdata[idx] : '0;
            e_tmo[r]   = to;
        end
    endtask

    task automatic model_reset(input int k);
        for (int c = k; c < MAXC; c++) begin
            e_psel[c] = '0; e_pen[c] = 0; e_rdy[c] = 0; e_err[c] = 0; e_rdata[c] = '0;
            e_tmo[c] = 0; e_addr[c] = '0; e_wr[c] = 0; e_wdata[c] = '0; e_strb[c] = '0; e_prot[c] = '0;
        end
    endtask

    always @(negedge PCLK) begin
        if (cyc < MAXC) begin
            chk("PSEL_m",    64'(PSEL_m),    64'(e_psel[cyc]));
            chk("PENABLE_m", 64'(PENABLE_m), 64'(e_pen[cyc]));
            chk("PREADY_s",  64'(PREADY_s),  64'(e_rdy[cyc]));
            chk("PSLVERR_s", 64'(PSLVERR_s), 64'(e_err[cyc]));
            chk("PRDATA_s",  64'(PRDATA_s),  64'(e_rdata[cyc]));
            chk("timeout_o", 64'(timeout_o), 64'(e_tmo[cyc]));
            chk("PADDR_m",   64'(PADDR_m),   64'(e_addr[cyc]));
            chk("PWRITE_m",  64'(PWRITE_m),  64'(e_wr[cyc]));
            chk("PWDATA_m",  64'(PWDATA_m),  64'(e_wdata[cyc]));
            chk("PSTRB_m",   64'(PSTRB_m),   64'(e_strb[cyc]));
            chk("PPROT_m",   64'(PPROT_m),   64'(e_prot[cyc]));
            chk("psel_onehot", 64'($countones(PSEL_m) <= 1), 64'(1));
        end
    end

    // ------------------------------------------------------------------
    // Upstream master
    // ------------------------------------------------------------------
    int          xfer_n    = 0;
    int          last_t0   = 0;
    int          last_resp = 0;
    logic [NS-1:0] last_psel;
    logic [DW-1:0] last_rdata;
    logic        last_err;
    logic        last_tmo;
    logic        drop_seen;

    // Called at posedge+1; returns at posedge+1 of the cycle after the response.
    task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d, input bit drop);
        int g;
        xfer_n++;
        PSEL_s = 1'b1; PENABLE_s = 1'b0; PADDR_s = a; PWRITE_s = w; PWDATA_s = d;
        PSTRB_s = w ? 4'hF : 4'h0; PPROT_s = 3'(xfer_n);
        last_t0 = cyc;
        model_xfer(cyc, a, w, d, PSTRB_s, PPROT_s, !drop);
        @(posedge PCLK); #1;
        last_psel = PSEL_m;
        if (drop) begin
            PSEL_s = 1'b0; PENABLE_s = 1'b0;
            drop_seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge PCLK); #1;
                drop_seen = drop_seen | PREADY_s;
            end
        end else begin
            PENABLE_s = 1'b1;
            g = 0;
            while (PREADY_s !== 1'b1 && g < 40) begin
                @(posedge PCLK); #1;
                g++;
            end
            if (PREADY_s !== 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL resp_wait: no PREADY_s within 40 cycles for addr 0x%0h", a);
            end
            last_resp = cyc; last_rdata = PRDATA_s; last_err = PSLVERR_s; last_tmo = timeout_o;
            @(posedge PCLK); #1;
            PSEL_s = 1'b0; PENABLE_s = 1'b0;
        end
    endtask

    int          b_t0[4];
    int          b_resp[4];
    logic        b_err[4];
    logic [DW-1:0] b_rdata[4];

    initial begin
        PSEL_s = 0; PENABLE_s = 0; PADDR_s = '0; PWRITE_s = 0; PWDATA_s = '0; PSTRB_s = '0; PPROT_s = '0;
        slv_waits[0] = 0;  slv_waits[1] = 0;  slv_waits[2] = 3;  slv_waits[3] = -1;
        slv_rdata[0] = 32'h0A0A_0000; slv_rdata[1] = 32'h1B1B_0001;
        slv_rdata[2] = 32'hDE00_0040; slv_rdata[3] = 32'h3C3C_0003;
        slv_err = 4'b0000;

        repeat (3) @(posedge PCLK); #1;
        chk("rst_PREADY_s", 64'(PREADY_s), 64'(0));
        chk("rst_PSEL_m",   64'(PSEL_m),   64'(0));
        chk("rst_PADDR_m",  64'(PADDR_m),  64'(0));
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // 1: zero-wait write to slave 1
        xfer(32'h1000_0000, 1'b1, 32'hAAAA_AAAA, 1'b0);
        chk("t1_psel_c1", 64'(last_psel), 64'(4'b0010));
        chk("t1_latency", 64'(last_resp - last_t0), 64'(3));
        chk("t1_slverr",  64'(last_err), 64'(0));
        chk("t1_pwdata",  64'(PWDATA_m), 64'(32'hAAAA_AAAA));

        // 2: read slave 2 with 3 wait states
        xfer(32'h2000_0040, 1'b0, 32'h0, 1'b0);
        chk("t2_latency", 64'(last_resp - last_t0), 64'(6));
        chk("t2_rdata",   64'(last_rdata), 64'(32'hDE00_0040));

        // 3: unmapped address
        xfer(32'h7000_0000, 1'b0, 32'h0, 1'b0);
        chk("t3_psel_c1", 64'(last_psel), 64'(0));
        chk("t3_latency", 64'(last_resp - last_t0), 64'(1));
        chk("t3_slverr",  64'(last_err), 64'(1));
        chk("t3_rdata",   64'(last_rdata), 64'(0));

        // 4: slave 3 never ready -> watchdog
        xfer(32'h3000_0000, 1'b0, 32'h0, 1'b0);
        chk("t4_latency", 64'(last_resp - last_t0), 64'(18));
        chk("t4_timeout", 64'(last_tmo), 64'(1));
        chk("t4_slverr",  64'(last_err), 64'(1));
        chk("t4_rdata",   64'(last_rdata), 64'(0));

        // Boundary: ready on the 16th ACCESS cycle still completes normally
        slv_waits[2] = 15;
        xfer(32'h2000_0000, 1'b0, 32'h0, 1'b0);
        chk("tb_latency", 64'(last_resp - last_t0), 64'(18));
        chk("tb_timeout", 64'(last_tmo), 64'(0));
        chk("tb_slverr",  64'(last_err), 64'(0));
        chk("tb_rdata",   64'(last_rdata), 64'(32'hDE00_0040));

        // 5: reset during ACCESS of slave 0
        slv_waits[0] = -1;
        PSEL_s = 1; PENABLE_s = 0; PADDR_s = 32'h0000_0020; PWRITE_s = 1;
        PWDATA_s = 32'h1234_5678; PSTRB_s = 4'hF; PPROT_s = 3'd0;
        model_xfer(cyc, PADDR_s, 1'b1, PWDATA_s, PSTRB_s, PPROT_s, 1'b1);
        @(posedge PCLK); #1; PENABLE_s = 1;
        @(posedge PCLK); #1;
        chk("t5_psel_pre", 64'(PSEL_m), 64'(4'b0001));
        @(posedge PCLK); #1;
        #1; PRESETn = 1'b0; model_reset(cyc);
        #1;
        chk("t5_psel_rst",   64'(PSEL_m),    64'(0));
        chk("t5_pen_rst",    64'(PENABLE_m), 64'(0));
        chk("t5_pwdata_rst", 64'(PWDATA_m),  64'(0));
        PSEL_s = 0; PENABLE_s = 0;
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESETn = 1'b1;
        slv_waits[0] = 0;
        @(posedge PCLK); #1;
        xfer(32'h0000_0010, 1'b1, 32'hCAFE_0010, 1'b0);
        chk("t5_latency", 64'(last_resp - last_t0), 64'(3));
        chk("t5_slverr",  64'(last_err), 64'(0));

        // 6: four back-to-back reads, slave 1 signals an error
        slv_waits[2] = 0; slv_waits[3] = 0; slv_err = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            xfer((32'(i) << 28) | 32'h100, 1'b0, 32'h0, 1'b0);
            b_t0[i] = last_t0; b_resp[i] = last_resp; b_err[i] = last_err; b_rdata[i] = last_rdata;
        end
        chk("t6_err0", 64'(b_err[0]), 64'(0));
        chk("t6_err1", 64'(b_err[1]), 64'(1));
        chk("t6_err2", 64'(b_err[2]), 64'(0));
        chk("t6_err3", 64'(b_err[3]), 64'(0));
        chk("t6_rdata0", 64'(b_rdata[0]), 64'(32'h0A0A_0000));
        chk("t6_rdata3", 64'(b_rdata[3]), 64'(32'h3C3C_0003));
        for (int i = 0; i < 3; i++) begin
            chk("t6_b2b", 64'(b_t0[i+1] - b_resp[i]), 64'(1));
        end
        slv_err = 4'b0000;

        // 7: upstream drops PSEL_s during SETUP; response discarded
        xfer(32'h0000_0030, 1'b0, 32'h0, 1'b1);
        chk("t7_no_ready", 64'(drop_seen), 64'(0));
        xfer(32'h0000_0034, 1'b0, 32'h0, 1'b0);
        chk("t7_recover", 64'(last_rdata), 64'(32'h0A0A_0000));

        repeat (5) @(posedge PCLK); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, got time %0t, required < 200000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
